// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'h9;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3_digit.sv
// One double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_c
);

  always_comb begin
    d_c = d_i;
    if (d_i >= BCD_W'(5)) d_c = d_i + BCD_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble),
// with start/busy/done handshake and saturation to all nines on overflow.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [WIDTH-1:0]          Bin,
  output logic                      Busy,
  output logic                      Done,
  output logic [BCD_W*DIGITS-1:0]   Bcd,
  output logic                      Overflow
);

  localparam int unsigned OUT_W      = BCD_W * DIGITS;
  // Enough scratch digits for any WIDTH-bit value, and at least one guard digit.
  localparam int unsigned SCR_DIGITS = max_u(DIGITS + 1, (WIDTH + 2) / 3);
  localparam int unsigned SCR_W      = BCD_W * SCR_DIGITS;
  localparam int unsigned CNT_W      = $clog2(WIDTH + 1);
  localparam int unsigned CMP_W      = WIDTH + 4;
  localparam longint unsigned LIMIT  = pow10(DIGITS);

  if (LIMIT >= (64'd1 << CMP_W)) begin : g_limit_check
    $error("bin2bcd_seq: 10^DIGITS does not fit the overflow comparison width");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [SCR_W-1:0]   scr_adj_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovfp_q, ovfp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adj
    bcd_add3_digit u_add3 (
      .d_i (scr_q[g*BCD_W +: BCD_W]),
      .d_c (scr_adj_c[g*BCD_W +: BCD_W])
    );
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          shift_d = Bin;
          scr_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          ovfp_d  = (CMP_W'(Bin) >= CMP_W'(LIMIT));
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        {scr_d, shift_d} = {scr_adj_c, shift_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          bcd_d   = ovfp_q ? {DIGITS{BCD_NINE}} : scr_d[OUT_W-1:0];
          ovf_d   = ovfp_q;
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Bcd      = bcd_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: two instances (WIDTH=6 and WIDTH=7, DIGITS=2) checked
// every cycle against a decimal-arithmetic model, plus literal expectations.
module tb_bin2bcd_seq;

  logic       Clock;
  logic       Reset;
  logic       start0, start1;
  logic [5:0] bin0;
  logic [6:0] bin1;
  logic       busy0, done0, ovf0;
  logic       busy1, done1, ovf1;
  logic [7:0] bcd0, bcd1;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq #(.WIDTH(6), .DIGITS(2)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .Start(start0), .Bin(bin0),
    .Busy(busy0), .Done(done0), .Bcd(bcd0), .Overflow(ovf0)
  );

  bin2bcd_seq #(.WIDTH(7), .DIGITS(2)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .Start(start1), .Bin(bin1),
    .Busy(busy1), .Done(done1), .Bcd(bcd1), .Overflow(ovf1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_bcd(input int v);
    if (v >= 100) return 'h99;
    return ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Behavioural model: ph counts cycles since acceptance (0 = idle).
  int ph [2];
  int val [2];
  int m_busy [2];
  int m_done [2];
  int m_bcd [2];
  int m_ovf [2];

  always @(posedge Clock or negedge Reset) begin
    int st [2];
    int bv [2];
    int w;
    if (!Reset) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; val[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_bcd[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      st[0] = int'(start0); st[1] = int'(start1);
      bv[0] = int'(bin0);   bv[1] = int'(bin1);
      for (int i = 0; i < 2; i++) begin
        w = (i == 0) ? 6 : 7;
        m_done[i] = 0;
        if (ph[i] == 0) begin
          if (st[i] != 0) begin
            ph[i] = 1; val[i] = bv[i]; m_busy[i] = 1;
          end
        end else if (ph[i] < w) begin
          ph[i]++;
        end else if (ph[i] == w) begin
          ph[i] = w + 1; m_busy[i] = 0; m_done[i] = 1;
          m_bcd[i] = exp_bcd(val[i]); m_ovf[i] = (val[i] >= 100) ? 1 : 0;
        end else begin
          ph[i] = 0;
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      check("busy0", 32'(busy0), 32'(m_busy[0]));
      check("done0", 32'(done0), 32'(m_done[0]));
      check("bcd0",  32'(bcd0),  32'(m_bcd[0]));
      check("ovf0",  32'(ovf0),  32'(m_ovf[0]));
      check("busy1", 32'(busy1), 32'(m_busy[1]));
      check("done1", 32'(done1), 32'(m_done[1]));
      check("bcd1",  32'(bcd1),  32'(m_bcd[1]));
      check("ovf1",  32'(ovf1),  32'(m_ovf[1]));
    end
  end

  task automatic cycle();
    @(posedge Clock);
    #2;
  endtask

  // One Start pulse; returns the cycle count to Done (-1 if it never came).
  task automatic convert(input int b0, input int b1, output int lat0, output int lat1);
    cycle();
    start0 = 1'b1; start1 = 1'b1;
    bin0 = 6'(b0); bin1 = 7'(b1);
    lat0 = -1; lat1 = -1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (c == 1) begin
        start0 = 1'b0; start1 = 1'b0;
        bin0 = 6'($urandom); bin1 = 7'($urandom);
      end
      @(negedge Clock);
      if (done0 === 1'b1 && lat0 < 0) lat0 = c;
      if (done1 === 1'b1 && lat1 < 0) lat1 = c;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy0"}, 32'(busy0), 32'd0);
    check({tag, "_done0"}, 32'(done0), 32'd0);
    check({tag, "_bcd0"},  32'(bcd0),  32'd0);
    check({tag, "_ovf0"},  32'(ovf0),  32'd0);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
    check({tag, "_bcd1"},  32'(bcd1),  32'd0);
    check({tag, "_ovf1"},  32'(ovf1),  32'd0);
  endtask

  initial begin
    int l0, l1, nd0, nd1;
    int dir_b0 [4] = '{0, 63, 9, 10};
    int dir_b1 [4] = '{99, 100, 127, 0};
    int dir_e0 [4] = '{'h00, 'h63, 'h09, 'h10};
    int dir_e1 [4] = '{'h99, 'h99, 'h99, 'h00};
    int dir_o1 [4] = '{0, 1, 1, 0};

    Reset = 1'b0; start0 = 1'b0; start1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (3) @(posedge Clock);
    #1;
    check_zero("reset");
    #1;
    Reset = 1'b1;

    // Directed values and latency, including digit and overflow boundaries.
    for (int k = 0; k < 4; k++) begin
      convert(dir_b0[k], dir_b1[k], l0, l1);
      check("lat0", 32'(l0), 32'd7);
      check("lat1", 32'(l1), 32'd8);
      check("dir_bcd0", 32'(bcd0), 32'(dir_e0[k]));
      check("dir_ovf0", 32'(ovf0), 32'd0);
      check("dir_bcd1", 32'(bcd1), 32'(dir_e1[k]));
      check("dir_ovf1", 32'(ovf1), 32'(dir_o1[k]));
    end

    // Start pulsed mid-conversion is ignored.
    cycle();
    start0 = 1'b1; start1 = 1'b1; bin0 = 6'd45; bin1 = 7'd45;
    nd0 = 0; nd1 = 0;
    for (int c = 1; c <= 16; c++) begin
      cycle();
      if (c == 1) begin start0 = 1'b0; start1 = 1'b0; end
      if (c == 3) begin start0 = 1'b1; start1 = 1'b1; bin0 = 6'd12; bin1 = 7'd12; end
      if (c == 4) begin start0 = 1'b0; start1 = 1'b0; end
      @(negedge Clock);
      if (done0 === 1'b1) nd0++;
      if (done1 === 1'b1) nd1++;
    end
    check("busy_ign_nd0", 32'(nd0), 32'd1);
    check("busy_ign_nd1", 32'(nd1), 32'd1);
    check("busy_ign_bcd0", 32'(bcd0), 32'h45);
    check("busy_ign_bcd1", 32'(bcd1), 32'h45);

    // Asynchronous reset mid-conversion.
    convert(63, 63, l0, l1);
    check("pre_rst_bcd0", 32'(bcd0), 32'h63);
    cycle();
    start0 = 1'b1; start1 = 1'b1; bin0 = 6'd20; bin1 = 7'd20;
    cycle();
    start0 = 1'b0; start1 = 1'b0;
    repeat (3) cycle();
    Reset = 1'b0;
    #1;
    check_zero("async_rst");
    cycle();
    Reset = 1'b1;
    nd0 = 0; nd1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clock);
      if (done0 === 1'b1) nd0++;
      if (done1 === 1'b1) nd1++;
    end
    check("rst_nodone0", 32'(nd0), 32'd0);
    check("rst_nodone1", 32'(nd1), 32'd0);
    convert(7, 7, l0, l1);
    check("post_rst_bcd0", 32'(bcd0), 32'h07);
    check("post_rst_bcd1", 32'(bcd1), 32'h07);

    // Start held high: back-to-back conversions with Bin changing every cycle.
    for (int c = 0; c < 40; c++) begin
      cycle();
      start0 = 1'b1; start1 = 1'b1;
      bin0 = 6'($urandom); bin1 = 7'($urandom);
    end
    cycle();
    start0 = 1'b0; start1 = 1'b0;
    repeat (12) cycle();

    // Random Start/Bin traffic.
    for (int c = 0; c < 400; c++) begin
      cycle();
      start0 = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      bin0 = 6'($urandom);
      bin1 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(95, 127)) : 7'($urandom);
    end
    cycle();
    start0 = 1'b0; start1 = 1'b0;
    repeat (12) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
